// File: rtl/sram_frame_writer.sv
// Pixel SRAM writer for the 800x600 VGA path. A small FIFO buffers incoming words,
// which are written only inside the blanking window; otherwise the display read address passes through.
module sram_frame_writer #(
  parameter int H_DISPLAY   = 800,
  parameter int V_DISPLAY   = 600,
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 628,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 480000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [10:0]                 hc,
  input  logic [9:0]                  vc,
  input  logic [19:0]                 vga_address,
  input  logic [15:0]                 s_data,
  input  logic                        s_sof,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [19:0]                 sram_address,
  output logic [15:0]                 sram_dq_out,
  output logic                        sram_dq_oe,
  output logic                        sram_we_n,
  output logic                        sram_oe_n,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_done
);
  // state   | meaning
  // IDLE    | display owns the bus, address passes through
  // SETUP   | address/data driven, reads disabled
  // WRITE   | we_n low for one cycle
  // RECOVER | we_n released, address/data held

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [10:0]   HC_DISP    = 11'(H_DISPLAY);
  localparam logic [10:0]   HC_CUTOFF  = 11'(H_TOTAL - 4);
  localparam logic [9:0]    VC_DISP    = 10'(V_DISPLAY);
  localparam logic [9:0]    VC_LASTACT = 10'(V_DISPLAY - 1);
  localparam logic [9:0]    VC_END     = 10'(V_TOTAL - 1);
  localparam logic [19:0]   LAST_ADDR  = 20'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, RECOVER} state_t;

  state_t        state, state_nx;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [16:0]   head;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [19:0]   wr_ptr, wr_addr, next_addr;
  logic          blank, next_line_active, window;
  logic          push, pop;

  // A write started at hc = H_TOTAL-5 still retires before the next active line.
  assign blank            = (hc >= HC_DISP) || (vc >= VC_DISP);
  assign next_line_active = (vc < VC_LASTACT) || (vc == VC_END);
  assign window           = blank && !((hc >= HC_CUTOFF) && next_line_active);

  assign s_ready   = !reset && (fifo_level != LEVEL_FULL);
  assign push      = s_valid && s_ready;
  assign pop       = (state == IDLE) && window && (fifo_level != '0);
  assign head      = mem[rd_idx];
  assign next_addr = head[16] ? 20'd0 : wr_ptr;

  assign sram_address = (state == IDLE) ? vga_address : wr_addr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= {s_sof, s_data};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = SETUP;
      SETUP:   state_nx = WRITE;
      WRITE:   state_nx = RECOVER;
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they change cleanly with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_idx      <= '0;
      wr_idx      <= '0;
      fifo_level  <= '0;
      wr_ptr      <= '0;
      wr_addr     <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b0;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
      frame_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_idx <= wr_idx + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (pop) begin
        rd_idx      <= rd_idx + 1'b1;
        wr_addr     <= next_addr;
        wr_ptr      <= (next_addr == LAST_ADDR) ? 20'd0 : next_addr + 20'd1;
        sram_dq_out <= head[15:0];
      end
      sram_we_n  <= (state_nx != WRITE);
      sram_oe_n  <= (state_nx != IDLE);
      sram_dq_oe <= (state_nx != IDLE);
      frame_done <= (state_nx == RECOVER) && (wr_addr == LAST_ADDR);
    end
  end
endmodule

// File: doc/sram_frame_writer.md
Name: sram_frame_writer

Overview:
- Upstream stage of the 800x600 VGA controller; owns the shared 1M x 16 pixel SRAM.
- Buffers incoming pixel words in a small FIFO and writes them to SRAM only during blanking, using the controller's hc/vc counters.
- Outside its write bursts, it passes the controller's read address straight through, so display reads are never disturbed.

Parameters:
- H_DISPLAY, 800, active pixels per line.
- V_DISPLAY, 600, active lines per frame.
- H_TOTAL, 1056, total clocks per line; hc range is 0..H_TOTAL-1.
- V_TOTAL, 628, total lines per frame; vc range is 0..V_TOTAL-1.
- FIFO_DEPTH, 16, input FIFO entries; must be a power of 2.
- FRAME_WORDS, 480000, SRAM words per frame; write pointer wraps here.

Ports:
- clk  in  1  pixel clock (40 MHz)
- reset  in  1  synchronous, active-high
- hc  in  11  horizontal count from the VGA controller
- vc  in  10  vertical count from the VGA controller
- vga_address  in  20  read address requested by the VGA controller
- s_data  in  16  pixel word to store
- s_sof  in  1  first word of a new frame; that word is written to address 0
- s_valid  in  1  s_data/s_sof valid
- s_ready  out  1  FIFO can accept a word
- sram_address  out  20  SRAM address bus
- sram_dq_out  out  16  SRAM write data
- sram_dq_oe  out  1  drive sram_dq_out onto the DQ bus
- sram_we_n  out  1  SRAM write enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_done  out  1  1-cycle pulse after the word at FRAME_WORDS-1 is written

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on port reset. All state changes on the rising edge of clk.
- Reset values:
  - FIFO empty, fifo_level=0, s_ready=0 while reset is high and 1 on the first cycle after.
  - wr_ptr=0, state=IDLE.
  - sram_we_n=1, sram_oe_n=0, sram_dq_oe=0, sram_dq_out=0, frame_done=0.
- Handshake: a push happens when s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH). Each entry stores {s_sof, s_data}. No fall-through: a word pushed in cycle N can be popped in cycle N+1 at the earliest. Simultaneous push and pop in one cycle leaves the level unchanged.
- Blanking and write window:
  - blank = (hc >= H_DISPLAY) || (vc >= V_DISPLAY).
  - next_line_active = (vc < V_DISPLAY-1) || (vc == V_TOTAL-1).
  - window = blank && !(hc >= H_TOTAL-4 && next_line_active). This guarantees the 3-cycle write finishes before active video resumes.
- FSM states: IDLE, SETUP, WRITE, RECOVER.
  - IDLE:
    - sram_address = vga_address, combinational pass-through with zero latency.
    - sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
    - If window && fifo_level!=0: pop the head and go to SETUP. wr_addr = sof ? 0 : wr_ptr. wr_ptr = (wr_addr == FRAME_WORDS-1) ? 0 : wr_addr+1. wr_data = head data.
  - SETUP: sram_address=wr_addr, sram_oe_n=1, sram_we_n=1, sram_dq_oe=1, sram_dq_out=wr_data. Go to WRITE.
  - WRITE: as SETUP, but sram_we_n=0. Go to RECOVER.
  - RECOVER: as SETUP (we_n back to 1; address and data held). frame_done=1 for this cycle if wr_addr==FRAME_WORDS-1. Go to IDLE.
- Output timing:
  - sram_we_n, sram_oe_n, sram_dq_oe and sram_dq_out are registered from state, so they are glitch-free.
  - sram_address is the only combinational output.
- Throughput: at most one word per 4 clocks (IDLE, SETUP, WRITE, RECOVER). Back-to-back writes continue for as long as window holds at each IDLE.
- Boundary conditions:
  - FIFO full: s_ready=0 and no push. A pop in the same cycle does not raise s_ready until the next cycle.
  - FIFO empty: stay in IDLE.
  - Pointer wrap: the word at 479999 is followed by address 0.
  - s_sof on any word forces address 0 for that word, regardless of wr_ptr.
  - Active video never sees a write state, because a write never starts outside window.
- Reset mid-write: state returns to IDLE at the reset edge and sram_we_n=1 immediately. The in-flight word is discarded, FIFO contents are cleared and wr_ptr=0.

Test Plan:
1. Reset sequence: assert reset 3 cycles -> sram_we_n=1, sram_oe_n=0, sram_dq_oe=0, s_ready=0 during reset. s_ready=1 on the first cycle after release. sram_address tracks vga_address.
2. Push 4 words (0x1111..0x4444, first with s_sof) during active video at vc=10, hc=100 -> no writes before hc=800. Then 4 writes to addresses 0..3 with data 0x1111..0x4444. Each write has we_n low for exactly 1 cycle, between SETUP and RECOVER.
3. Push 20 words continuously from empty during active video -> s_ready falls after 16 accepts, fifo_level=16. s_ready returns the cycle after the first pop.
4. FIFO non-empty with vc=10, hc=1052 (H_TOTAL-4) -> no write starts. With hc=1051 -> the write starts and RECOVER ends at hc=1054, before hc wraps to 0.
5. Preload wr_ptr to 479999 and write 2 words in vertical blank (vc=610) -> addresses 479999 then 0. frame_done pulses 1 cycle, in RECOVER of the first word.
6. Assert reset during the WRITE state -> next cycle sram_we_n=1, sram_dq_oe=0, fifo_level=0. The next frame's first sof word lands at address 0.
